// File: rtl/sc_pkg.sv
// Shared types and defaults for the stochastic bipolar decoder.
package sc_pkg;

  localparam int unsigned DATAWD_DEFAULT = 8;

  typedef enum logic [1:0] {
    Idle,
    Count,
    Done
  } sc_state_e;

endpackage

// File: rtl/sc_bi_decoder_if.sv
// Handshake/data bundle between a stream producer/consumer and the decoder.
interface sc_bi_decoder_if
  import sc_pkg::*;
#(
  parameter int unsigned DATAWD = DATAWD_DEFAULT
);

  logic              iStart;
  logic              iBit;
  logic              iBitEn;
  logic              iReady;
  logic              oBusy;
  logic              oValid;
  logic [DATAWD-1:0] oData;
  logic              oSat;

  modport master (
    output iStart, iBit, iBitEn, iReady,
    input  oBusy, oValid, oData, oSat
  );

  modport slave (
    input  iStart, iBit, iBitEn, iReady,
    output oBusy, oValid, oData, oSat
  );

endinterface

// File: rtl/sc_ones_counter.sv
// Counts accepted '1' bits; clear has priority over increment.
module sc_ones_counter #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sc_bi_decoder.sv
// Bipolar stochastic-stream decoder: counts ones over a 2^DATAWD-bit window and
// returns an offset-binary result with a saturation flag through a valid/ready hold.
module sc_bi_decoder
  import sc_pkg::*;
#(
  parameter int unsigned DATAWD = DATAWD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sc_bi_decoder_if.slave         bus_io
);

  localparam int unsigned CntW = DATAWD + 1;

  sc_state_e         state_q;
  logic [DATAWD-1:0] win_q;
  logic [DATAWD-1:0] data_q;
  logic              sat_q;
  logic              busy_q;
  logic              valid_q;

  logic              ones_clr;
  logic              ones_en;
  logic [CntW-1:0]   ones_cnt;
  logic [CntW-1:0]   ones_fin;
  logic              win_last;

  // A new window starts from Idle, or straight out of Done when the result is taken.
  assign ones_clr = bus_io.iStart &&
                    ((state_q == Idle) || ((state_q == Done) && bus_io.iReady));
  assign ones_en  = (state_q == Count) && bus_io.iBitEn;
  assign ones_fin = ones_cnt + {{DATAWD{1'b0}}, bus_io.iBit};
  assign win_last = (win_q == {DATAWD{1'b1}});

  sc_ones_counter #(
    .Width (CntW)
  ) u_ones_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ones_clr),
    .en_i  (ones_en),
    .inc_i (bus_io.iBit),
    .cnt_o (ones_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      win_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (bus_io.iStart) begin
            state_q <= Count;
            win_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        Count: begin
          if (bus_io.iBitEn) begin
            // Wraps to zero on the final bit of the window.
            win_q <= win_q + DATAWD'(1);
            if (win_last) begin
              state_q <= Done;
              data_q  <= ones_fin[DATAWD] ? {DATAWD{1'b1}} : ones_fin[DATAWD-1:0];
              sat_q   <= ones_fin[DATAWD];
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        Done: begin
          if (bus_io.iReady) begin
            valid_q <= 1'b0;
            if (bus_io.iStart) begin
              state_q <= Count;
              win_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= Idle;
            end
          end
        end
        default: begin
          state_q <= Idle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.oBusy  = busy_q;
  assign bus_io.oValid = valid_q;
  assign bus_io.oData  = data_q;
  assign bus_io.oSat   = sat_q;

endmodule

// File: tb/tb_sc_bi_decoder.sv
// Randomized bench for sc_bi_decoder against a ones-count reference model.
module tb_sc_bi_decoder;

  localparam int unsigned DW = 8;
  localparam int N = 1 << DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sc_bi_decoder_if #(.DATAWD(DW)) bus_if ();

  sc_bi_decoder #(
    .DATAWD (DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_data = 0;
  int exp_sat  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  int'(bus_if.oBusy),  0);
    check_eq({tag, "_valid"}, int'(bus_if.oValid), 0);
    check_eq({tag, "_data"},  int'(bus_if.oData),  0);
    check_eq({tag, "_sat"},   int'(bus_if.oSat),   0);
  endtask

  task automatic start_window();
    bus_if.iStart = 1'b1;
    tick();
    bus_if.iStart = 1'b0;
    check_eq("start_busy", int'(bus_if.oBusy), 1);
  endtask

  // pattern: 0 ones, 1 alternating 1/0, 2 zeros, 3 biased random, 4 64 ones then zeros.
  // stall: 0 none, 1 exact alternation with iBit=0 on idle cycles, 2 random.
  // abort_at >= 0 stops feeding after that many accepted bits.
  task automatic feed_window(input int pattern, input int stall, input int abort_at);
    bit bits[N];
    int sum = 0;
    int bad = 0;
    int p = $urandom_range(100);
    for (int i = 0; i < N; i++) begin
      case (pattern)
        0:       bits[i] = 1'b1;
        1:       bits[i] = (i % 2 == 0);
        2:       bits[i] = 1'b0;
        4:       bits[i] = (i < 64);
        default: bits[i] = ($urandom_range(99) < p);
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        bus_if.iBitEn = 1'b0;
        bus_if.iStart = 1'b0;
        return;
      end
      if (stall == 1) begin
        bus_if.iBitEn = 1'b0;
        bus_if.iBit   = 1'b0;
        tick();
        if (!bus_if.oBusy || bus_if.oValid) bad++;
      end else if (stall == 2) begin
        while ($urandom_range(99) < 30) begin
          bus_if.iBitEn = 1'b0;
          bus_if.iBit   = 1'($urandom_range(1));
          bus_if.iStart = 1'($urandom_range(1));
          tick();
          if (!bus_if.oBusy || bus_if.oValid) bad++;
        end
      end
      bus_if.iBitEn = 1'b1;
      bus_if.iBit   = bits[i];
      bus_if.iStart = 1'($urandom_range(1));
      tick();
      sum += int'(bits[i]);
      if (i < N - 1 && (!bus_if.oBusy || bus_if.oValid)) bad++;
    end
    bus_if.iBitEn = 1'b0;
    bus_if.iBit   = 1'($urandom_range(1));
    bus_if.iStart = 1'b0;
    exp_data = (sum > N - 1) ? N - 1 : sum;
    exp_sat  = (sum == N) ? 1 : 0;
    check_eq("busy_during_count", bad, 0);
    check_eq("result_valid", int'(bus_if.oValid), 1);
    check_eq("result_busy",  int'(bus_if.oBusy),  0);
    check_eq("result_data",  int'(bus_if.oData),  exp_data);
    check_eq("result_sat",   int'(bus_if.oSat),   exp_sat);
  endtask

  // Hold the result for 'hold' cycles (with a stray iStart), then take it.
  task automatic finish_window(input int hold, input bit chain);
    int bad = 0;
    bus_if.iReady = 1'b0;
    for (int k = 0; k < hold; k++) begin
      bus_if.iStart = (k == hold / 2);
      bus_if.iBitEn = 1'($urandom_range(1));
      tick();
      if (!bus_if.oValid || bus_if.oBusy || int'(bus_if.oData) != exp_data ||
          int'(bus_if.oSat) != exp_sat) bad++;
    end
    bus_if.iBitEn = 1'b0;
    check_eq("hold_stable", bad, 0);
    bus_if.iReady = 1'b1;
    bus_if.iStart = chain;
    tick();
    bus_if.iReady = 1'($urandom_range(1));
    bus_if.iStart = 1'b0;
    check_eq("release_valid", int'(bus_if.oValid), 0);
    check_eq("release_busy",  int'(bus_if.oBusy),  int'(chain));
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs(tag);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus_if.iStart = 1'b0;
    bus_if.iBit   = 1'b0;
    bus_if.iBitEn = 1'b0;
    bus_if.iReady = 1'b0;
    #12;
    check_idle_outputs("reset");

    // iStart already high when reset releases: taken at the very next edge.
    tick();
    bus_if.iStart = 1'b1;
    rst_n = 1'b1;
    tick();
    bus_if.iStart = 1'b0;
    check_eq("first_start_busy", int'(bus_if.oBusy), 1);

    bus_if.iReady = 1'b1;
    feed_window(0, 0, -1);
    finish_window(0, 1'b0);

    start_window();
    feed_window(1, 0, -1);
    finish_window(0, 1'b0);

    start_window();
    feed_window(2, 0, -1);
    finish_window(0, 1'b0);

    start_window();
    feed_window(0, 1, -1);
    finish_window(20, 1'b1);
    feed_window(4, 0, -1);
    finish_window(0, 1'b0);

    start_window();
    feed_window(3, 2, 100);
    async_reset("reset_mid_window");
    start_window();
    feed_window(3, 0, -1);
    finish_window(3, 1'b0);

    start_window();
    feed_window(3, 2, -1);
    async_reset("reset_in_done");

    for (int w = 0; w < 12; w++) begin
      start_window();
      feed_window(3, 2, -1);
      finish_window($urandom_range(5), 1'($urandom_range(1)));
      if (bus_if.oBusy) begin
        feed_window(3, 0, -1);
        finish_window(0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_bi_decoder.md
SC_BI_DECODER -- requirements
Module: sc_bi_decoder

Interface
REQ-001 SHALL have parameter DATAWD, default 8, binary word width; the decode window is 2^DATAWD accepted bits.
REQ-002 SHALL have port clk  input  1  clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iStart  input  1  request a new decode window.
REQ-005 SHALL have port iBit  input  1  bipolar stochastic bit (1 = +1, 0 = -1).
REQ-006 SHALL have port iBitEn  input  1  iBit is valid this cycle.
REQ-007 SHALL have port oBusy  output  1  window in progress.
REQ-008 SHALL have port oValid  output  1  oData/oSat hold a result.
REQ-009 SHALL have port iReady  input  1  consumer accepts the result.
REQ-010 SHALL have port oData  output  DATAWD  decoded value, offset-binary: value = 2*oData/2^DATAWD - 1.
REQ-011 SHALL have port oSat  output  1  the ones count equalled 2^DATAWD and oData was clamped.

Function
REQ-012 SHALL implement FSM states IDLE, COUNT and DONE.
REQ-013 IDLE: when iStart=1 at a clock edge, SHALL clear the ones counter and window counter and enter COUNT.
REQ-014 COUNT: at each edge with iBitEn=1, SHALL increment the window counter and add iBit to the ones counter (DATAWD+1 bits wide).
REQ-015 COUNT: at an edge with iBitEn=0, SHALL hold both counters (stall).
REQ-016 COUNT: the edge that accepts the 2^DATAWD-th bit SHALL register the result and enter DONE; oValid SHALL be 1 in the following cycle.
REQ-017 Result SHALL be: oData = min(ones, 2^DATAWD-1); oSat = 1 iff ones = 2^DATAWD.
REQ-018 DONE: oValid=1, and oData/oSat SHALL remain stable until an edge with iReady=1.
REQ-019 DONE with iReady=1 and iStart=0 SHALL return to IDLE.
REQ-020 DONE with iReady=1 and iStart=1 on the same edge SHALL clear the counters and enter COUNT directly (back-to-back windows).
REQ-021 iStart SHALL be ignored in COUNT, and in DONE while iReady=0.
REQ-022 iBit/iBitEn SHALL be ignored outside COUNT.
REQ-023 oBusy SHALL be 1 exactly in COUNT; oValid SHALL be 1 exactly in DONE.
REQ-024 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-025 The window counter SHALL be DATAWD bits and SHALL wrap to 0 when it leaves COUNT.

Reset
REQ-026 When rst_n=0, the block SHALL force state to IDLE, both counters to 0, oData=0, oSat=0, oBusy=0 and oValid=0, at any time including mid-window or mid-DONE.
REQ-027 A window aborted by reset SHALL produce no result.
REQ-028 The first iStart SHALL be sampled at the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package sc_pkg SHALL hold the state enum (IDLE, COUNT, DONE) and the default DATAWD constant.
REQ-030 The ones counter with clear, enable and increment SHALL be one sub-module, sc_ones_counter, parameterised by width.
REQ-031 The FSM, window counter and result registers SHALL reside in sc_bi_decoder.

Verification (DATAWD=8)
REQ-032 Start, then 256 cycles of iBitEn=1, iBit=1, iReady=1 -> oValid for 1 cycle with oData=255, oSat=1; oValid in the cycle after the 256th bit.
REQ-033 Start, then 256 bits alternating 1/0 -> oData=128, oSat=0; all-zero stream -> oData=0.
REQ-034 Start, then iBitEn toggling 1/0 with iBit=1 on enabled cycles and 0 on disabled cycles, 512 cycles -> oData=255, oSat=1; oBusy high throughout COUNT.
REQ-035 Result with iReady=0 for 20 cycles -> oValid and oData stable for 20 cycles; iStart pulse during this hold is ignored; iReady=1 -> IDLE next cycle.
REQ-036 iReady=1 and iStart=1 on the same edge in DONE -> COUNT next cycle with counters 0; a second window of 64 ones then 192 zeros -> oData=64.
REQ-037 rst_n pulsed low at bit 100 of a window -> all outputs 0 immediately, IDLE; a new start then yields the correct result for a fresh window.
